// File: rtl/signal_cfg_shadow_slice_if.sv
// Config staging bus between the register bank (master) and the shadow slicer (slave).
// Pure wiring: no storage, so no latency of its own.
// No backpressure: the master may raise update_req at any time.
interface signal_cfg_shadow_slice_if #(
  parameter int NUM_COMP  = 4,
  parameter int CNT_WIDTH = 8
);
  localparam int CFG_DATA_WIDTH = 64 * (1 + 3 * NUM_COMP);

  logic [CFG_DATA_WIDTH-1:0] cfg_data;
  logic                      update_req;
  logic                      sync_mode;
  logic                      sync_tick;

  logic [47:0]               ramp_freq;
  logic [15:0]               offset;
  logic [48*NUM_COMP-1:0]    comp_cfg;
  logic [16*NUM_COMP-1:0]    comp_amp;
  logic [48*NUM_COMP-1:0]    comp_freq;
  logic [48*NUM_COMP-1:0]    comp_phase;
  logic [NUM_COMP-1:0]       comp_changed;
  logic                      update_pending;
  logic                      update_done;
  logic [CNT_WIDTH-1:0]      update_count;

  modport master (
    output cfg_data, update_req, sync_mode, sync_tick,
    input  ramp_freq, offset, comp_cfg, comp_amp, comp_freq, comp_phase,
           comp_changed, update_pending, update_done, update_count
  );

  modport slave (
    input  cfg_data, update_req, sync_mode, sync_tick,
    output ramp_freq, offset, comp_cfg, comp_amp, comp_freq, comp_phase,
           comp_changed, update_pending, update_done, update_count
  );
endinterface

// File: rtl/signal_cfg_shadow_slice.sv
// Double-buffered slicer: staged config words become active outputs only on an apply.
// Latency: 1 cycle from an immediate request (or the sync tick) to updated outputs.
// No backpressure: requests are always taken; while pending, newer requests overwrite the snapshot.
module signal_cfg_shadow_slice #(
  parameter int  NUM_COMP       = 4,
  parameter int  CNT_WIDTH      = 8,
  localparam int CFG_DATA_WIDTH = 64 * (1 + 3 * NUM_COMP)
) (
  input  logic                          aclk,
  input  logic                          rst,
  signal_cfg_shadow_slice_if.slave      bus
);

  typedef enum logic {IDLE, PENDING} state_t;

  state_t                    state_q, state_d;
  logic [CFG_DATA_WIDTH-1:0] snap_q;
  logic [CFG_DATA_WIDTH-1:0] active_q;
  logic [CFG_DATA_WIDTH-1:0] src_m;
  logic [NUM_COMP-1:0]       changed_q, changed_d;
  logic                      done_q;
  logic [CNT_WIDTH-1:0]      count_q;
  logic                      apply;
  logic                      use_snap;
  logic                      snap_load;

  // Decide whether this edge applies, from which source, or just refreshes the snapshot.
  always_comb begin
    state_d   = state_q;
    apply     = 1'b0;
    use_snap  = 1'b0;
    snap_load = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.update_req) begin
          if (!bus.sync_mode || bus.sync_tick) begin
            apply = 1'b1;
          end else begin
            snap_load = 1'b1;
            state_d   = PENDING;
          end
        end
      end
      PENDING: begin
        if (bus.sync_tick) begin
          // A request arriving with the tick carries the newest data.
          apply    = 1'b1;
          use_snap = !bus.update_req;
          state_d  = IDLE;
        end else if (bus.update_req && bus.sync_mode) begin
          snap_load = 1'b1;
        end else if (bus.update_req) begin
          apply   = 1'b1;
          state_d = IDLE;
        end else if (!bus.sync_mode) begin
          // Sync mode withdrawn: flush the held snapshot now.
          apply    = 1'b1;
          use_snap = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Select the apply source, clear reserved fields, and flag components that differ.
  always_comb begin
    src_m = use_snap ? snap_q : bus.cfg_data;
    for (int k = 0; k < NUM_COMP; k++) begin
      src_m[64*(2+3*k)+48 +: 16] = '0;
      src_m[64*(3+3*k)+48 +: 16] = '0;
    end
    changed_d = '0;
    for (int k = 0; k < NUM_COMP; k++) begin
      changed_d[k] = (src_m[64*(1+3*k) +: 192] != active_q[64*(1+3*k) +: 192]);
    end
  end

  // FSM state, snapshot, active registers and per-apply pulses.
  always_ff @(posedge aclk) begin
    if (rst) begin
      state_q   <= IDLE;
      snap_q    <= '0;
      active_q  <= '0;
      changed_q <= '0;
      done_q    <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      done_q    <= apply;
      changed_q <= apply ? changed_d : '0;
      if (snap_load) begin
        snap_q <= bus.cfg_data;
      end
      if (apply) begin
        active_q <= src_m;
        count_q  <= count_q + CNT_WIDTH'(1);
      end
    end
  end

  assign bus.ramp_freq      = active_q[47:0];
  assign bus.offset         = active_q[63:48];
  assign bus.comp_changed   = changed_q;
  assign bus.update_done    = done_q;
  assign bus.update_count   = count_q;
  assign bus.update_pending = (state_q == PENDING);

  for (genvar g = 0; g < NUM_COMP; g++) begin : g_comp
    assign bus.comp_cfg[48*g +: 48]   = active_q[64*(1+3*g) +: 48];
    assign bus.comp_amp[16*g +: 16]   = active_q[64*(1+3*g)+48 +: 16];
    assign bus.comp_freq[48*g +: 48]  = active_q[64*(2+3*g) +: 48];
    assign bus.comp_phase[48*g +: 48] = active_q[64*(3+3*g) +: 48];
  end

endmodule
